megarom_mapper: RTL

- Parametrised successor to the fixed-mapper MegaROM cartridge: one block serves Konami, Konami-SCC, ASCII8, ASCII16 and plain-ROM modes, selected at run time by MODE.
- Decodes slot bus writes into bank registers and translates Z80 reads in 4000h-BFFFh into RAM addresses.
- Performs a req/ack read transaction with RAM, holding WAIT_n low until data returns.
- Sits between the cartridge bus slice and the RAM host port; optionally flags the SCC register window.

---
 rtl/megarom_pkg.sv | 27 ++
 rtl/megarom_bank_decode.sv | 57 +++++
 rtl/megarom_mapper.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/megarom_pkg.sv
// megarom_pkg: mapper mode and read-FSM types plus shared constants for the MegaROM mapper.
package megarom_pkg;

    typedef enum logic [2:0] {
        KONAMI     = 3'd0,
        KONAMI_SCC = 3'd1,
        ASCII8     = 3'd2,
        ASCII16    = 3'd3,
        PLAIN      = 3'd4
    } mapper_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_ACK,
        HOLD
    } rd_state_e;

    localparam logic [15:0] PAGE_BASE = 16'h4000;
    localparam logic [7:0]  SCC_BANK  = 8'h3F;

    // Konami variants power up with bank i = i; every other mode starts at bank 0.
    function automatic logic identity_banks(input logic [2:0] mode);
        return (mode == KONAMI) || (mode == KONAMI_SCC);
    endfunction

endpackage

// File: rtl/megarom_bank_decode.sv
// megarom_bank_decode: turns MODE and ADDR[15:11] into bank-write and bank-read selects.
module megarom_bank_decode
    import megarom_pkg::*;
(
    input  logic [2:0] mode,
    input  logic [4:0] addr_hi,
    output logic       wr_en,
    output logic [1:0] wr_idx,
    output logic       rd_valid,
    output logic [1:0] rd_idx,
    output logic       rd_wide,
    output logic       rd_plain
);

    logic       in_window;
    logic [1:0] page;

    // Inside 4000h-BFFFh, ADDR[15:13]-2 reduces to ADDR[14:13]+2 modulo 4.
    always_comb begin
        in_window = addr_hi[4] ^ addr_hi[3];
        page      = addr_hi[3:2] + 2'd2;
        wr_en     = 1'b0;
        wr_idx    = page;
        rd_valid  = 1'b0;
        rd_idx    = page;
        rd_wide   = 1'b0;
        rd_plain  = 1'b0;
        case (mode)
            KONAMI: begin
                wr_en    = in_window && (page != 2'd0);
                rd_valid = in_window;
            end
            KONAMI_SCC: begin
                wr_en    = in_window && (addr_hi[1:0] == 2'b10);
                rd_valid = in_window;
            end
            ASCII8: begin
                wr_en    = (addr_hi[4:2] == 3'b011);
                wr_idx   = addr_hi[1:0];
                rd_valid = in_window;
            end
            ASCII16: begin
                wr_en    = (addr_hi[4:2] == 3'b011) && !addr_hi[0];
                wr_idx   = {1'b0, addr_hi[1]};
                rd_valid = in_window;
                rd_idx   = {1'b0, page[1]};
                rd_wide  = 1'b1;
            end
            PLAIN: begin
                rd_valid = in_window;
                rd_plain = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/megarom_mapper.sv
// megarom_mapper: run-time selectable MegaROM mapper with a req/ack RAM read port.
// Optional MEGAROM_SCC_DETECT_EN flags the SCC register window and keeps those reads off RAM.
module megarom_mapper
    import megarom_pkg::*;
#(
    parameter int unsigned BANK_W     = 8,
    parameter int unsigned RAM_ADDR_W = 22,
    parameter int unsigned RAM_BASE   = 0
) (
    input  logic                  CLK,
    input  logic                  RESET_n,
    input  logic [2:0]            MODE,
    input  logic [BANK_W-1:0]     BANK_MASK,
    input  logic [15:0]           ADDR,
    input  logic [7:0]            DIN,
    input  logic                  SLTSL_n,
    input  logic                  MERQ_n,
    input  logic                  RD_n,
    input  logic                  WR_n,
    output logic [7:0]            DOUT,
    output logic                  BUSDIR_n,
    output logic                  WAIT_n,
    output logic [RAM_ADDR_W-1:0] RAM_ADDR,
    output logic                  RAM_REQ,
    input  logic                  RAM_ACK,
    input  logic [7:0]            RAM_RDATA,
    output logic                  SCC_SEL
);

    logic [BANK_W-1:0]     bank [4];
    logic [2:0]            mode_q;
    logic                  wr_q, rd_q, aborted;
    logic                  bus_sel, wr_edge, rd_edge, start, ack_take;
    logic                  wr_en, rd_valid, rd_wide, rd_plain;
    logic [1:0]            wr_idx, rd_idx;
    logic [BANK_W-1:0]     bank_sel;
    logic [RAM_ADDR_W-1:0] addr_calc;
    rd_state_e             state, state_next;

    megarom_bank_decode u_decode (
        .mode     (MODE),
        .addr_hi  (ADDR[15:11]),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .rd_valid (rd_valid),
        .rd_idx   (rd_idx),
        .rd_wide  (rd_wide),
        .rd_plain (rd_plain)
    );

`ifdef MEGAROM_SCC_DETECT_EN
    assign SCC_SEL = (MODE == KONAMI_SCC) && (ADDR[15:8] == 8'h98) &&
                     (32'(bank[2]) == 32'(SCC_BANK)) && !SLTSL_n && !MERQ_n;
`else
    assign SCC_SEL = 1'b0;
`endif

    always_comb begin
        bus_sel  = !SLTSL_n && !MERQ_n;
        wr_edge  = wr_q && !WR_n;
        rd_edge  = rd_q && !RD_n;
        start    = (state == IDLE) && rd_edge && bus_sel && rd_valid && !SCC_SEL;
        ack_take = ((state == REQ) || (state == WAIT_ACK)) && RAM_ACK;
    end

    always_comb begin
        bank_sel = bank[rd_idx] & BANK_MASK;
        if (rd_plain)
            addr_calc = RAM_ADDR_W'(RAM_BASE) + RAM_ADDR_W'(ADDR - PAGE_BASE);
        else if (rd_wide)
            addr_calc = RAM_ADDR_W'(RAM_BASE) + (RAM_ADDR_W'(bank_sel) << 14) + RAM_ADDR_W'(ADDR[13:0]);
        else
            addr_calc = RAM_ADDR_W'(RAM_BASE) + (RAM_ADDR_W'(bank_sel) << 13) + RAM_ADDR_W'(ADDR[12:0]);
    end

    // Banks reset to the Konami layout; mode_q resets to KONAMI so any other MODE reloads on the first clock.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            mode_q <= KONAMI;
            for (int unsigned i = 0; i < 4; i++) bank[i] <= BANK_W'(i);
        end else begin
            mode_q <= MODE;
            if (MODE != mode_q) begin
                for (int unsigned i = 0; i < 4; i++)
                    bank[i] <= identity_banks(MODE) ? BANK_W'(i) : '0;
            end else if (wr_edge && bus_sel && wr_en) begin
                bank[wr_idx] <= DIN[BANK_W-1:0];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            wr_q <= 1'b1;
            rd_q <= 1'b1;
        end else begin
            wr_q <= WR_n;
            rd_q <= RD_n;
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            RAM_ADDR <= '0;
            DOUT     <= '0;
            aborted  <= 1'b0;
        end else begin
            if (start)    RAM_ADDR <= addr_calc;
            if (ack_take) DOUT     <= RAM_RDATA;
            if (state == IDLE)         aborted <= 1'b0;
            else if (RD_n || SLTSL_n)  aborted <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) state <= IDLE;
        else          state <= state_next;
    end

    // A read abandoned by the bus still waits for its ACK but skips HOLD so data is never driven.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start) state_next = REQ;
            REQ,
            WAIT_ACK: begin
                if (RAM_ACK)
                    state_next = (aborted || RD_n || SLTSL_n) ? IDLE : HOLD;
                else if (state == REQ)
                    state_next = WAIT_ACK;
            end
            HOLD:     if (RD_n || SLTSL_n) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        RAM_REQ  = (state == REQ);
        WAIT_n   = !((state == REQ) || (state == WAIT_ACK));
        BUSDIR_n = !((state == HOLD) && !RD_n && !SLTSL_n);
    end

endmodule
